// File: rtl/ex_stage_exmem.sv
// EX stage (ALU, RegDst mux, branch adder, iterative multiplier) feeding the EX/MEM register.
// Latency: 1 cycle for ALU ops; a multiply spends DW+2 cycles in EX, with stall high for DW+1 of them.
// Backpressure: combinational stall holds ID/EX while a multiply runs; flush squashes EX and drops stall.
module ex_stage_exmem #(
    parameter int         DW        = 32,
    parameter logic [5:0] MUL_FUNCT = 6'h18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          regwr,
    input  logic          memreg,
    input  logic          memwr,
    input  logic          memrd,
    input  logic          br,
    input  logic          aluop1,
    input  logic          aluop2,
    input  logic          alusrc,
    input  logic          regdst,
    input  logic [DW-1:0] npc,
    input  logic [DW-1:0] reg1,
    input  logic [DW-1:0] reg2,
    input  logic [DW-1:0] signext,
    input  logic [4:0]    inst2016,
    input  logic [4:0]    inst1511,
    output logic          stall,
    output logic          regwro,
    output logic          memrego,
    output logic          memwro,
    output logic          memrdo,
    output logic          bro,
    output logic          zeroo,
    output logic [DW-1:0] brtargeto,
    output logic [DW-1:0] aluresulto,
    output logic [DW-1:0] reg2o,
    output logic [4:0]    wrego
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t        state;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;

    logic [5:0]    funct;
    logic [DW-1:0] opb;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] res_sel;
    logic          is_mul;
    logic          load;

    assign funct  = signext[5:0];
    assign opb    = alusrc ? signext : reg2;
    assign is_mul = aluop1 & ~aluop2 & (funct == MUL_FUNCT);

    always_comb begin
        alu_res = '0;
        case ({aluop1, aluop2})
            2'b00:   alu_res = reg1 + opb;
            2'b01:   alu_res = reg1 - opb;
            default: begin
                case (funct)
                    6'h20:   alu_res = reg1 + opb;
                    6'h22:   alu_res = reg1 - opb;
                    6'h24:   alu_res = reg1 & opb;
                    6'h25:   alu_res = reg1 | opb;
                    6'h2A:   alu_res = {{(DW-1){1'b0}}, ($signed(reg1) < $signed(opb))};
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    // Reset also forces stall low so upstream is never held while the pipe is cleared.
    assign stall = rst & ~flush & (((state == IDLE) & is_mul) | (state == MUL));

    // EX/MEM takes a real instruction only for a single-cycle op or a finished product.
    assign load    = ~flush & (((state == IDLE) & ~is_mul) | (state == DONE));
    assign res_sel = (state == DONE) ? acc : alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            regwro     <= 1'b0;
            memrego    <= 1'b0;
            memwro     <= 1'b0;
            memrdo     <= 1'b0;
            bro        <= 1'b0;
            zeroo      <= 1'b0;
            brtargeto  <= '0;
            aluresulto <= '0;
            reg2o      <= '0;
            wrego      <= '0;
        end else begin
            regwro  <= load & regwr;
            memrego <= load & memreg;
            memwro  <= load & memwr;
            memrdo  <= load & memrd;
            bro     <= load & br;
            if (load) begin
                zeroo      <= (res_sel == '0);
                aluresulto <= res_sel;
                brtargeto  <= npc + (signext << 2);
                reg2o      <= reg2;
                wrego      <= regdst ? inst1511 : inst2016;
            end

            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_mul) begin
                            mcand  <= reg1;
                            mplier <= reg2;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end
                    end
                    MUL: begin
                        acc    <= acc + (mplier[0] ? mcand : '0);
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(DW - 1))
                            state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_exmem.sv
// Directed bench for ex_stage_exmem: ALU ops, branch target, multiply timing, flush and async reset.
module tb_ex_stage_exmem;
    logic        clk, rst, flush;
    logic        regwr, memreg, memwr, memrd, br;
    logic        aluop1, aluop2, alusrc, regdst;
    logic [31:0] npc, reg1, reg2, signext;
    logic [4:0]  inst2016, inst1511;
    logic        stall, regwro, memrego, memwro, memrdo, bro, zeroo;
    logic [31:0] brtargeto, aluresulto, reg2o;
    logic [4:0]  wrego;

    int checks = 0;
    int passed = 0;

    ex_stage_exmem dut (
        .clk(clk), .rst(rst), .flush(flush),
        .regwr(regwr), .memreg(memreg), .memwr(memwr), .memrd(memrd), .br(br),
        .aluop1(aluop1), .aluop2(aluop2), .alusrc(alusrc), .regdst(regdst),
        .npc(npc), .reg1(reg1), .reg2(reg2), .signext(signext),
        .inst2016(inst2016), .inst1511(inst1511),
        .stall(stall), .regwro(regwro), .memrego(memrego), .memwro(memwro),
        .memrdo(memrdo), .bro(bro), .zeroo(zeroo), .brtargeto(brtargeto),
        .aluresulto(aluresulto), .reg2o(reg2o), .wrego(wrego)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_in();
        flush = 0; regwr = 0; memreg = 0; memwr = 0; memrd = 0; br = 0;
        aluop1 = 0; aluop2 = 0; alusrc = 0; regdst = 0;
        npc = 0; reg1 = 0; reg2 = 0; signext = 0; inst2016 = 0; inst1511 = 0;
    endtask

    // R-type instruction writing rd
    task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        clear_in();
        aluop1 = 1; signext = {26'd0, f}; reg1 = a; reg2 = b;
        regwr = 1; regdst = 1; inst1511 = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 0;
        #1;
        checks++; if (aluresulto !== 32'd0) $display("FAIL reset_alu got %h exp 0", aluresulto); else passed++;
        checks++; if ({regwro, memrego, memwro, memrdo, bro, zeroo} !== 6'd0)
            $display("FAIL reset_ctrl got %b exp 000000", {regwro, memrego, memwro, memrdo, bro, zeroo}); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        step();
        rst = 1;
        step();
    endtask

    task automatic test_add();
        set_r(6'h20, 32'd5, 32'd7, 5'd9);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL add_stall got %b exp 0", stall); else passed++;
        step();
        checks++; if (aluresulto !== 32'd12) $display("FAIL add_result got %h exp 0000000c", aluresulto); else passed++;
        checks++; if (wrego !== 5'd9) $display("FAIL add_wreg got %0d exp 9", wrego); else passed++;
        checks++; if (regwro !== 1'b1 || zeroo !== 1'b0)
            $display("FAIL add_flags got regwr=%b zero=%b exp 1 0", regwro, zeroo); else passed++;
    endtask

    task automatic test_branch();
        clear_in();
        aluop2 = 1; reg1 = 32'h55; reg2 = 32'h55; br = 1; npc = 32'h100; signext = 32'd4;
        step();
        checks++; if (zeroo !== 1'b1 || aluresulto !== 32'd0)
            $display("FAIL beq_zero got zero=%b res=%h exp 1 0", zeroo, aluresulto); else passed++;
        checks++; if (bro !== 1'b1 || regwro !== 1'b0)
            $display("FAIL beq_ctrl got br=%b regwr=%b exp 1 0", bro, regwro); else passed++;
        checks++; if (brtargeto !== 32'h110) $display("FAIL beq_target got %h exp 00000110", brtargeto); else passed++;
    endtask

    task automatic test_logic_slt();
        set_r(6'h2A, 32'hFFFF_FFFD, 32'd2, 5'd1);
        step();
        checks++; if (aluresulto !== 32'd1) $display("FAIL slt_neg got %h exp 1", aluresulto); else passed++;
        set_r(6'h2A, 32'd2, 32'hFFFF_FFFD, 5'd1);
        step();
        checks++; if (aluresulto !== 32'd0 || zeroo !== 1'b1)
            $display("FAIL slt_pos got %h zero=%b exp 0 1", aluresulto, zeroo); else passed++;
        set_r(6'h24, 32'h0000_F0F0, 32'h0000_FF00, 5'd2);
        step();
        checks++; if (aluresulto !== 32'h0000_F000) $display("FAIL and got %h exp 0000f000", aluresulto); else passed++;
        set_r(6'h25, 32'h0000_F0F0, 32'h0000_FF00, 5'd2);
        step();
        checks++; if (aluresulto !== 32'h0000_FFF0) $display("FAIL or got %h exp 0000fff0", aluresulto); else passed++;
        set_r(6'h22, 32'd3, 32'd10, 5'd2);
        step();
        checks++; if (aluresulto !== 32'hFFFF_FFF9) $display("FAIL rsub got %h exp fffffff9", aluresulto); else passed++;
        set_r(6'h21, 32'd3, 32'd10, 5'd2);
        step();
        checks++; if (aluresulto !== 32'd0 || zeroo !== 1'b1)
            $display("FAIL bad_funct got %h zero=%b exp 0 1", aluresulto, zeroo); else passed++;
    endtask

    task automatic test_imm_mem();
        clear_in();
        alusrc = 1; reg1 = 32'd10; signext = 32'hFFFF_FFFF; reg2 = 32'h0000_DEAD;
        inst2016 = 5'd17; inst1511 = 5'd3; memwr = 1; memreg = 1; npc = 32'h200;
        step();
        checks++; if (aluresulto !== 32'd9) $display("FAIL addi got %h exp 9", aluresulto); else passed++;
        checks++; if (wrego !== 5'd17) $display("FAIL regdst_rt got %0d exp 17", wrego); else passed++;
        checks++; if (reg2o !== 32'h0000_DEAD) $display("FAIL store_data got %h exp 0000dead", reg2o); else passed++;
        checks++; if ({memwro, memrego, memrdo} !== 3'b110)
            $display("FAIL mem_ctrl got %b exp 110", {memwro, memrego, memrdo}); else passed++;
        checks++; if (brtargeto !== 32'h1FC) $display("FAIL neg_target got %h exp 000001fc", brtargeto); else passed++;
        clear_in();
        aluop2 = 1; reg1 = 32'd0; reg2 = 32'd1;
        step();
        checks++; if (aluresulto !== 32'hFFFF_FFFF || zeroo !== 1'b0)
            $display("FAIL sub_wrap got %h zero=%b exp ffffffff 0", aluresulto, zeroo); else passed++;
    endtask

    task automatic test_mul();
        int n = 0;
        int bub = 0;
        set_r(6'h18, 32'd3, 32'hFFFF_FFFC, 5'd3);
        #1;
        while (stall === 1'b1 && n < 100) begin
            n++;
            step();
            if (regwro !== 1'b0) bub++;
        end
        checks++; if (n != 33) $display("FAIL mul_stall_cycles got %0d exp 33", n); else passed++;
        checks++; if (bub != 0) $display("FAIL mul_bubbles got %0d non-bubbles exp 0", bub); else passed++;
        step();
        checks++; if (aluresulto !== 32'hFFFF_FFF4) $display("FAIL mul_result got %h exp fffffff4", aluresulto); else passed++;
        checks++; if (regwro !== 1'b1 || wrego !== 5'd3 || zeroo !== 1'b0)
            $display("FAIL mul_ctrl got regwr=%b wreg=%0d zero=%b exp 1 3 0", regwro, wrego, zeroo); else passed++;
        checks++; if (reg2o !== 32'hFFFF_FFFC) $display("FAIL mul_reg2 got %h exp fffffffc", reg2o); else passed++;
        set_r(6'h20, 32'd100, 32'd1, 5'd4);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL post_mul_stall got %b exp 0", stall); else passed++;
        step();
        checks++; if (aluresulto !== 32'd101 || wrego !== 5'd4)
            $display("FAIL post_mul_add got %h wreg=%0d exp 00000065 4", aluresulto, wrego); else passed++;
    endtask

    task automatic test_flush();
        set_r(6'h18, 32'd6, 32'd7, 5'd5);
        step();
        repeat (9) step();
        checks++; if (stall !== 1'b1) $display("FAIL flush_pre_stall got %b exp 1", stall); else passed++;
        flush = 1;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall); else passed++;
        step();
        flush = 0;
        checks++; if (regwro !== 1'b0) $display("FAIL flush_bubble got %b exp 0", regwro); else passed++;
        set_r(6'h20, 32'd1, 32'd2, 5'd6);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_idle got %b exp 0", stall); else passed++;
        step();
        checks++; if (aluresulto !== 32'd3 || regwro !== 1'b1)
            $display("FAIL flush_next_add got %h regwr=%b exp 3 1", aluresulto, regwro); else passed++;
        // flush wins over a multiply start in IDLE
        set_r(6'h18, 32'd6, 32'd7, 5'd5);
        flush = 1;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_start_stall got %b exp 0", stall); else passed++;
        step();
        checks++; if (regwro !== 1'b0) $display("FAIL flush_start_bubble got %b exp 0", regwro); else passed++;
        set_r(6'h20, 32'd4, 32'd4, 5'd6);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_start_idle got %b exp 0", stall); else passed++;
        step();
    endtask

    task automatic test_async_reset();
        int n = 0;
        set_r(6'h20, 32'd5, 32'd7, 5'd9);
        step();
        set_r(6'h18, 32'd6, 32'd7, 5'd9);
        step();
        repeat (5) step();
        #3;
        rst = 0;
        #1;
        checks++; if (aluresulto !== 32'd0 || wrego !== 5'd0)
            $display("FAIL arst_data got %h wreg=%0d exp 0 0", aluresulto, wrego); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL arst_stall got %b exp 0", stall); else passed++;
        set_r(6'h18, 32'd2, 32'd2, 5'd7);
        step();
        rst = 1;
        #1;
        while (stall === 1'b1 && n < 100) begin
            n++;
            step();
        end
        checks++; if (n != 33) $display("FAIL arst_mul_cycles got %0d exp 33", n); else passed++;
        step();
        checks++; if (aluresulto !== 32'd4 || regwro !== 1'b1 || wrego !== 5'd7)
            $display("FAIL arst_mul_result got %h regwr=%b wreg=%0d exp 4 1 7", aluresulto, regwro, wrego); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_logic_slt();
        test_imm_mem();
        test_mul();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
